cheri_regfile_mp: RTL
=====================

Name: cheri_regfile_mp

Overview:
- Multi-port CHERI capability register file: NRD read ports, NWR write ports, each register holding a 32-bit data word plus reg_cap_t metadata.
- Keeps the tag-reservation/revocation ready vector for load-capability pipelining.
- Adds a background tag-sweep engine that walks all capability registers. For each tagged one it queries an external revocation checker over a req/gnt/rsp handshake, and clears the tag if the capability is revoked.
- Sits in the ID/WB stages in place of the single-write-port register file.

Parameters:
- NREGS, 32, architectural registers (16 or 32).
- NCAPS, 32, registers carrying capability metadata (NCAPS <= NREGS).
- NRD, 2, read ports (1..4).
- NWR, 1, write ports (1..2).
- TRVKBypass, 1, forward same-cycle revocation to the read ports and reg_rdy_o.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- raddr_i  in  NRD x 5  read addresses
- rdata_o  out  NRD x 32  read data
- rcap_o  out  NRD x reg_cap_t  read capability metadata
- waddr_i  in  NWR x 5  write addresses
- wdata_i  in  NWR x 32  write data
- wcap_i  in  NWR x reg_cap_t  write metadata
- we_i  in  NWR  write enables; data and cap are always written together
- trsv_addr_i  in  5  tag reservation address
- trsv_en_i  in  1  tag reservation enable
- trvk_addr_i  in  5  tag revocation address
- trvk_en_i  in  1  tag revocation enable
- trvk_clrtag_i  in  1  clear the tag on revocation
- reg_rdy_o  out  32  per-register ready vector
- sweep_start_i  in  1  start-sweep pulse
- sweep_abort_i  in  1  abort the sweep
- sweep_busy_o  out  1  sweep in progress
- sweep_done_o  out  1  one-cycle completion pulse
- rvk_req_o  out  1  revocation query valid
- rvk_addr_o  out  32  data word (address) of the capability under test
- rvk_gnt_i  in  1  query accepted
- rvk_rsp_valid_i  in  1  query response valid
- rvk_revoked_i  in  1  capability is revoked
- sweep_rvk_cnt_o  out  16  revoked-tag counter

Behaviour:
- Reset (rst_i sampled high at a clock edge):
  - all data words clear to 0; all caps clear to NULL_REG_CAP;
  - reg_rdy_o = all ones; FSM in IDLE;
  - sweep_busy_o, sweep_done_o and rvk_req_o = 0; rvk_addr_o = 0; sweep_rvk_cnt_o = 0.
  - Reset asserted mid-sweep abandons the sweep; a response arriving afterwards is ignored.
- Reads are combinational, zero latency.
  - Register 0 reads 0/NULL_REG_CAP.
  - An address >= NCAPS returns NULL_REG_CAP metadata.
  - No write-to-read bypass: in the cycle of a write, the read returns the old value.
- Writes commit at the clock edge.
  - Writes to register 0 are ignored.
  - If several write ports target the same register, the highest-indexed port wins.
- Tag-clear priority for a register, highest first:
  1. trvk_en_i & trvk_clrtag_i clears valid;
  2. otherwise a write stores wcap_i;
  3. otherwise a sweep clear zeroes valid.
- reg_rdy_o:
  - a bit goes to 0 on trsv_en_i and back to 1 on trvk_en_i; trsv takes priority when both hit the same register;
  - bit 0 and bits >= NCAPS are always 1.
  - With TRVKBypass=1: reg_rdy_o ORs in the current trvk decode, and rcap_o[k].valid is forced to 0 when trvk_en_i & trvk_clrtag_i & trvk_addr_i == raddr_i[k].
- Sweep FSM states: IDLE, SCAN, REQ, WAIT, DONE.
  - IDLE: sweep_start_i → SCAN with idx = 1. Start is ignored when not in IDLE.
  - SCAN: examines one register per cycle.
    - If cap[idx].valid: latch rvk_addr_o = data[idx], clear the dirty flag, go to REQ.
    - Else if idx == NCAPS-1: go to DONE.
    - Else idx++.
  - REQ: rvk_req_o = 1, rvk_addr_o held stable until rvk_gnt_i; then go to WAIT. rvk_req_o falls the cycle after the grant.
  - WAIT: on rvk_rsp_valid_i:
    - if rvk_revoked_i & !dirty: clear cap[idx].valid at that edge and increment the counter;
    - then idx++ to SCAN, or go to DONE when idx == NCAPS-1.
  - DONE: sweep_done_o = 1 for one cycle → IDLE.
- Dirty flag: set in REQ/WAIT when any write port or a trvk clear targets idx. A dirty result is discarded with no tag clear.
  - A write and a revoked response to idx in the same cycle: the write wins and the clear is dropped.
- Abort:
  - in SCAN or REQ: go to IDLE next cycle, with no DONE pulse;
  - in WAIT: wait for rvk_rsp_valid_i, discard the result, go to IDLE.
- sweep_busy_o = (state != IDLE).
- A response outside WAIT is ignored.

Optional Feature:
- Macro: CHERI_SWEEP_STATS_EN.
- Defined:
  - sweep_rvk_cnt_o is a 16-bit saturating count (holds at 16'hFFFF) of tags cleared by the sweep;
  - it clears to 0 on reset and on each accepted sweep_start_i.
- Undefined: sweep_rvk_cnt_o is tied to 0 and no counter flops exist.

Test Plan:
- NWR=2, both ports write register 5 in the same cycle with 32'hA and 32'hB → register 5 reads 32'hB next cycle. A write to register 0 → reads 0.
- trsv_en_i on register 7, then trvk_en_i on register 7 three cycles later → reg_rdy_o[7] is 0 for 3 cycles, then 1. With TRVKBypass, reg_rdy_o[7] is 1 in the trvk cycle itself.
- Registers 3 and 9 tagged, 3 not revoked and 9 revoked, rvk_gnt_i after 2 cycles → exactly two requests, with rvk_addr_o = data[3] then data[9]; reg 9 valid = 0 and reg 3 valid = 1; sweep_done_o pulses once; count = 1 with the stats macro defined.
- Write to register 9 while the sweep is in WAIT for 9, followed by a revoked response → register 9 keeps the new cap with its tag set; count unchanged.
- sweep_abort_i in WAIT, response arrives 4 cycles later → no tag cleared; IDLE one cycle after the response; no sweep_done_o pulse.
- rst_i asserted in REQ → rvk_req_o = 0 and sweep_busy_o = 0 next cycle; a stale rvk_rsp_valid_i is ignored.

Source files
------------

// File: rtl/cheri_regfile_mp.sv
// Multi-port CHERI capability register file with tag-reservation ready vector and background tag-sweep engine.
// Optional feature: define CHERI_SWEEP_STATS_EN to enable the saturating revoked-tag counter on sweep_rvk_cnt_o.

package cheri_regfile_mp_pkg;
    typedef struct packed {
        logic        valid;
        logic [1:0]  top_cor;
        logic        base_cor;
        logic [4:0]  exp;
        logic [8:0]  top;
        logic [8:0]  base;
        logic [3:0]  otype;
        logic [11:0] cperms;
    } reg_cap_t;

    localparam reg_cap_t NULL_REG_CAP = '{valid: 1'b0, top_cor: 2'd0, base_cor: 1'b0, exp: 5'd24,
                                          top: 9'h100, base: 9'h000, otype: 4'h0, cperms: 12'h000};
endpackage

module cheri_regfile_mp
    import cheri_regfile_mp_pkg::*;
#(
    parameter int unsigned NREGS      = 32,
    parameter int unsigned NCAPS      = 32,
    parameter int unsigned NRD        = 2,
    parameter int unsigned NWR        = 1,
    parameter bit          TRVKBypass = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NRD-1:0][4:0]   raddr_i,
    output logic [NRD-1:0][31:0]  rdata_o,
    output reg_cap_t [NRD-1:0]    rcap_o,
    input  logic [NWR-1:0][4:0]   waddr_i,
    input  logic [NWR-1:0][31:0]  wdata_i,
    input  reg_cap_t [NWR-1:0]    wcap_i,
    input  logic [NWR-1:0]        we_i,
    input  logic [4:0]            trsv_addr_i,
    input  logic                  trsv_en_i,
    input  logic [4:0]            trvk_addr_i,
    input  logic                  trvk_en_i,
    input  logic                  trvk_clrtag_i,
    output logic [31:0]           reg_rdy_o,
    input  logic                  sweep_start_i,
    input  logic                  sweep_abort_i,
    output logic                  sweep_busy_o,
    output logic                  sweep_done_o,
    output logic                  rvk_req_o,
    output logic [31:0]           rvk_addr_o,
    input  logic                  rvk_gnt_i,
    input  logic                  rvk_rsp_valid_i,
    input  logic                  rvk_revoked_i,
    output logic [15:0]           sweep_rvk_cnt_o
);

    typedef enum logic [2:0] {IDLE, SCAN, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic [31:0] data [NREGS];
    reg_cap_t    cap  [NCAPS];
    logic [31:0] rdy;
    logic [4:0]  idx;
    logic        dirty;
    logic        abort_pend;

    logic [31:0] trvk_dec;
    logic [31:0] trsv_dec;
    logic        trvk_clr;
    logic        idx_hit;
    logic        sweep_clr;
    logic [31:0] scan_data;
    logic        scan_valid;
    logic        last_idx;

    always_comb begin
        trvk_dec = '0;
        trsv_dec = '0;
        if (trvk_en_i) trvk_dec[trvk_addr_i] = 1'b1;
        if (trsv_en_i) trsv_dec[trsv_addr_i] = 1'b1;
    end

    assign trvk_clr = trvk_en_i & trvk_clrtag_i;

    // Any write or tag clear landing on the register under test invalidates the pending answer.
    always_comb begin
        idx_hit = trvk_clr && (trvk_addr_i == idx);
        for (int unsigned p = 0; p < NWR; p++) begin
            if (we_i[p] && (waddr_i[p] == idx)) idx_hit = 1'b1;
        end
    end

    always_comb begin
        scan_data  = '0;
        scan_valid = 1'b0;
        for (int unsigned i = 1; i < NCAPS; i++) begin
            if (idx == 5'(i)) begin
                scan_data  = data[i];
                scan_valid = cap[i].valid;
            end
        end
    end

    assign last_idx  = (idx == 5'(NCAPS - 1));
    assign sweep_clr = (state == WAIT) && rvk_rsp_valid_i && rvk_revoked_i && !dirty
                       && !idx_hit && !abort_pend && !sweep_abort_i;

    // Later assignments win: sweep clear, then writes (highest port last), then trvk clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NREGS; i++) data[i] <= '0;
            for (int unsigned i = 0; i < NCAPS; i++) cap[i] <= NULL_REG_CAP;
        end else begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                for (int unsigned p = 0; p < NWR; p++) begin
                    if (we_i[p] && (waddr_i[p] == 5'(i))) data[i] <= wdata_i[p];
                end
            end
            for (int unsigned i = 1; i < NCAPS; i++) begin
                if (sweep_clr && (idx == 5'(i))) cap[i].valid <= 1'b0;
                for (int unsigned p = 0; p < NWR; p++) begin
                    if (we_i[p] && (waddr_i[p] == 5'(i))) cap[i] <= wcap_i[p];
                end
                if (trvk_clr && (trvk_addr_i == 5'(i))) cap[i].valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdy <= '1;
        end else begin
            for (int unsigned i = 0; i < 32; i++) begin
                if ((i == 0) || (i >= NCAPS)) rdy[i] <= 1'b1;
                else if (trsv_dec[i])         rdy[i] <= 1'b0;
                else if (trvk_dec[i])         rdy[i] <= 1'b1;
            end
        end
    end

    assign reg_rdy_o = TRVKBypass ? (rdy | trvk_dec) : rdy;

    always_comb begin
        for (int unsigned k = 0; k < NRD; k++) begin
            rdata_o[k] = '0;
            rcap_o[k]  = NULL_REG_CAP;
            for (int unsigned i = 1; i < NREGS; i++) begin
                if (raddr_i[k] == 5'(i)) rdata_o[k] = data[i];
            end
            for (int unsigned i = 1; i < NCAPS; i++) begin
                if (raddr_i[k] == 5'(i)) rcap_o[k] = cap[i];
            end
            if (TRVKBypass && trvk_clr && (trvk_addr_i == raddr_i[k])) rcap_o[k].valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            idx          <= '0;
            dirty        <= 1'b0;
            abort_pend   <= 1'b0;
            rvk_req_o    <= 1'b0;
            rvk_addr_o   <= '0;
            sweep_busy_o <= 1'b0;
            sweep_done_o <= 1'b0;
        end else begin
            sweep_done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sweep_start_i) begin
                        state        <= SCAN;
                        idx          <= 5'd1;
                        abort_pend   <= 1'b0;
                        sweep_busy_o <= 1'b1;
                    end
                end
                SCAN: begin
                    if (sweep_abort_i) begin
                        state        <= IDLE;
                        sweep_busy_o <= 1'b0;
                    end else if (scan_valid) begin
                        rvk_addr_o <= scan_data;
                        dirty      <= 1'b0;
                        rvk_req_o  <= 1'b1;
                        state      <= REQ;
                    end else if (last_idx) begin
                        state        <= DONE;
                        sweep_done_o <= 1'b1;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                REQ: begin
                    if (idx_hit) dirty <= 1'b1;
                    if (sweep_abort_i) begin
                        state        <= IDLE;
                        rvk_req_o    <= 1'b0;
                        sweep_busy_o <= 1'b0;
                    end else if (rvk_gnt_i) begin
                        rvk_req_o <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (idx_hit) dirty <= 1'b1;
                    if (sweep_abort_i) abort_pend <= 1'b1;
                    if (rvk_rsp_valid_i) begin
                        if (abort_pend || sweep_abort_i) begin
                            state        <= IDLE;
                            abort_pend   <= 1'b0;
                            sweep_busy_o <= 1'b0;
                        end else if (last_idx) begin
                            state        <= DONE;
                            sweep_done_o <= 1'b1;
                        end else begin
                            idx   <= idx + 5'd1;
                            state <= SCAN;
                        end
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    sweep_busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CHERI_SWEEP_STATS_EN
    logic [15:0] rvk_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvk_cnt <= '0;
        end else if ((state == IDLE) && sweep_start_i) begin
            rvk_cnt <= '0;
        end else if (sweep_clr && (rvk_cnt != 16'hFFFF)) begin
            rvk_cnt <= rvk_cnt + 16'd1;
        end
    end

    assign sweep_rvk_cnt_o = rvk_cnt;
`else
    assign sweep_rvk_cnt_o = '0;
`endif

endmodule
